// File: rtl/bid_stim_gen.sv
// bid_stim_gen: constrained-random stimulus generator for the bid/auction model.
// A bank of Galois LFSRs feeds per-channel and global fields. One vector is
// registered per LOAD cycle and held stable in VALID until the consumer takes it.
// A run stops after the configured number of accepted vectors.
module bid_stim_gen #(
    parameter int          N_CH    = 3,
    parameter int          AMT_W   = 16,
    parameter int          DATA_W  = 32,
    parameter int          NUM_OPS = 8,
    parameter logic [31:0] SEED    = 32'h0000_0001,
    localparam int         OP_W    = $clog2(NUM_OPS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [15:0]             cfg_runs,
    input  logic [31:0]             cfg_seed,
    input  logic                    cfg_corner_en,
    input  logic [1:0]              cfg_ctl_wt,
    output logic                    stim_valid,
    input  logic                    stim_ready,
    output logic [N_CH-1:0]         bid,
    output logic [N_CH-1:0]         retract,
    output logic [N_CH*AMT_W-1:0]   bid_amt,
    output logic [DATA_W-1:0]       c_data,
    output logic                    c_start,
    output logic [OP_W-1:0]         op,
    output logic [15:0]             sent_cnt,
    output logic                    busy,
    output logic                    done
);

    localparam logic [31:0]   LFSR_MASK  = 32'h8020_0003;
    localparam logic [31:0]   SEED_STEP  = 32'h9E37_79B9;
    localparam logic [OP_W:0] NUM_OPS_W  = NUM_OPS[OP_W:0];
    localparam logic [OP_W-1:0] NUM_OPS_LO = NUM_OPS[OP_W-1:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_VALID = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One Galois step, shifting right and folding the feedback mask in on a 1 out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        lfsr_next = {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_MASK : 32'h0000_0000);
    endfunction

    // Per-LFSR seed; a zero seed would lock the register, so it becomes 1.
    function automatic logic [31:0] seed_of(input logic [31:0] base, input int idx);
        logic [31:0] s;
        s = base ^ (32'(idx) * SEED_STEP);
        seed_of = (s == 32'h0000_0000) ? 32'h0000_0001 : s;
    endfunction

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [N_CH+1:0][31:0]   lfsr_r;
    logic [15:0]             runs_r;
    logic                    corner_r;
    logic [1:0]              wt_r;

    logic                    accept_start_s;
    logic                    load_s;
    logic                    hshk_s;
    logic                    last_s;

    logic [N_CH-1:0]         bid_s;
    logic [N_CH-1:0]         retract_s;
    logic [N_CH*AMT_W-1:0]   amt_s;
    logic [DATA_W-1:0]       c_data_s;
    logic                    c_start_s;
    logic [OP_W-1:0]         op_raw_s;
    logic [OP_W-1:0]         op_s;

    assign accept_start_s = !abort && start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign load_s         = !abort && (state_r == ST_LOAD);
    assign hshk_s         = !abort && (state_r == ST_VALID) && stim_ready;
    assign last_s         = ((sent_cnt + 16'd1) == runs_r);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; abort overrides every other event.
    always_comb begin
        state_nx_s = state_r;
        if (abort) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_nx_s = (cfg_runs == 16'd0) ? ST_DONE : ST_LOAD;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                ST_LOAD: begin
                    state_nx_s = ST_VALID;
                end
                ST_VALID: begin
                    if (stim_ready) begin
                        state_nx_s = last_s ? ST_DONE : ST_LOAD;
                    end else begin
                        state_nx_s = ST_VALID;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // Field extraction from the current LFSR values, with corner and weight rules.
    always_comb begin
        bid_s     = {N_CH{1'b0}};
        retract_s = {N_CH{1'b0}};
        amt_s     = {(N_CH*AMT_W){1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            bid_s[i]     = (lfsr_r[i][3:2] <= wt_r);
            retract_s[i] = (lfsr_r[i][5:4] <= wt_r);
            if (corner_r && (lfsr_r[i][1:0] == 2'b00)) begin
                amt_s[i*AMT_W +: AMT_W] = {AMT_W{1'b0}};
            end else if (corner_r && (lfsr_r[i][1:0] == 2'b11)) begin
                amt_s[i*AMT_W +: AMT_W] = {AMT_W{1'b1}};
            end else begin
                amt_s[i*AMT_W +: AMT_W] = lfsr_r[i][AMT_W+5:6];
            end
        end
        if (corner_r && (lfsr_r[N_CH][1:0] == 2'b00)) begin
            c_data_s = {DATA_W{1'b0}};
        end else if (corner_r && (lfsr_r[N_CH][1:0] == 2'b11)) begin
            c_data_s = {DATA_W{1'b1}};
        end else begin
            c_data_s = lfsr_r[N_CH+1][DATA_W-1:0];
        end
        c_start_s = (lfsr_r[N_CH][3:2] <= wt_r);
        // Raw opcode is below 2*NUM_OPS, so one conditional subtract is the modulo.
        op_raw_s = lfsr_r[N_CH][OP_W+3:4];
        if ({1'b0, op_raw_s} >= NUM_OPS_W) begin
            op_s = op_raw_s - NUM_OPS_LO;
        end else begin
            op_s = op_raw_s;
        end
    end

    // Config latch, LFSR bank, vector fields and accepted-vector counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH + 2; i++) begin
                lfsr_r[i] <= seed_of(SEED, i);
            end
            runs_r   <= 16'd0;
            corner_r <= 1'b0;
            wt_r     <= 2'd0;
            bid      <= {N_CH{1'b0}};
            retract  <= {N_CH{1'b0}};
            bid_amt  <= {(N_CH*AMT_W){1'b0}};
            c_data   <= {DATA_W{1'b0}};
            c_start  <= 1'b0;
            op       <= {OP_W{1'b0}};
            sent_cnt <= 16'd0;
        end else if (accept_start_s) begin
            for (int i = 0; i < N_CH + 2; i++) begin
                lfsr_r[i] <= seed_of(cfg_seed, i);
            end
            runs_r   <= cfg_runs;
            corner_r <= cfg_corner_en;
            wt_r     <= cfg_ctl_wt;
            sent_cnt <= 16'd0;
        end else if (load_s) begin
            for (int i = 0; i < N_CH + 2; i++) begin
                lfsr_r[i] <= lfsr_next(lfsr_r[i]);
            end
            bid     <= bid_s;
            retract <= retract_s;
            bid_amt <= amt_s;
            c_data  <= c_data_s;
            c_start <= c_start_s;
            op      <= op_s;
        end else if (hshk_s) begin
            sent_cnt <= sent_cnt + 16'd1;
        end else begin
            sent_cnt <= sent_cnt;
        end
    end

    // Status flags registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stim_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            stim_valid <= (state_nx_s == ST_VALID);
            busy       <= (state_nx_s == ST_LOAD) || (state_nx_s == ST_VALID);
            done       <= (state_nx_s == ST_DONE);
        end
    end

endmodule
